// File: rtl/fetch_line_buffer.sv
// fetch_line_buffer
//   Instruction-fetch front end with a single-entry line buffer. Issues
//   line-aligned reads on an AR/R style interface, keeps the returned line,
//   and hands one instruction per cycle to decode over valid/ready. A
//   redirect reloads the fetch PC, reuses the buffered line on a tag hit and
//   drops a read that is still in flight.
//
// Ports
//   clk, rst        clock / asynchronous active-high reset
//   redirectValid   load redirectPc as the new fetch PC this cycle
//   redirectPc      new fetch PC (bits [1:0] ignored)
//   instValid/instReady/inst/instPc   instruction handshake towards decode
//   arValid/arReady/arAddr            line read request towards memory
//   rValid/rReady/rData               line read data from memory
module fetch_line_buffer #(
  parameter int              AW       = 16,
  parameter int              DW       = 128,
  parameter int              IW       = 32,
  parameter int              BW       = $clog2(DW >> 3),
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirectValid,
  input  logic [AW-1:0] redirectPc,
  output logic          instValid,
  input  logic          instReady,
  output logic [IW-1:0] inst,
  output logic [AW-1:0] instPc,
  output logic          arValid,
  input  logic          arReady,
  output logic [AW-1:0] arAddr,
  input  logic          rValid,
  output logic          rReady,
  input  logic [DW-1:0] rData
);

  localparam int NW = DW / IW;  // instruction words per line
  localparam int TW = AW - BW;  // line tag width

  typedef enum logic [1:0] {BOOT, REQ, WAIT, SERVE} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   pc_reg, pc_next;
  logic [DW-1:0]   line_data_reg;
  logic [TW-1:0]   line_tag_reg;
  logic            line_valid_reg;
  logic            drop_reg, drop_next;
  logic            line_load;

  logic [AW-1:0]   redir_pc;
  logic [TW-1:0]   pc_tag;
  logic            pc_hit;
  logic            redir_hit;
  logic            last_word;
  logic [IW-1:0]   line_words [NW];

  // Low two bits of the redirect target are forced to zero (word aligned).
  assign redir_pc  = redirectPc & ~AW'(3);
  assign pc_tag    = pc_reg[AW-1:BW];
  assign pc_hit    = line_valid_reg && (line_tag_reg == pc_tag);
  // Compared against the buffer as it stands now: a line arriving in the
  // same cycle as a redirect is discarded, so it never counts as a hit.
  assign redir_hit = line_valid_reg && (line_tag_reg == redir_pc[AW-1:BW]);
  assign last_word = &pc_reg[BW-1:2];

  generate
    for (genvar gi = 0; gi < NW; gi++) begin : g_word
      assign line_words[gi] = line_data_reg[gi*IW +: IW];
    end
  endgenerate

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= BOOT;
      pc_reg         <= RESET_PC;
      line_data_reg  <= '0;
      line_tag_reg   <= '0;
      line_valid_reg <= 1'b0;
      drop_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      drop_reg  <= drop_next;
      if (line_load) begin
        line_data_reg  <= rData;
        line_tag_reg   <= pc_tag;
        line_valid_reg <= 1'b1;
      end
    end
  end

  // Next-state logic; a redirect overrides the normal flow.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    drop_next  = drop_reg;
    line_load  = 1'b0;

    case (state_reg)
      BOOT: state_next = REQ;
      REQ: begin
        if (arReady) state_next = WAIT;
      end
      WAIT: begin
        if (rValid) begin
          if (drop_reg) begin
            // Stale line: pc was already moved by the redirect.
            drop_next  = 1'b0;
            state_next = pc_hit ? SERVE : REQ;
          end else begin
            line_load  = 1'b1;
            state_next = SERVE;
          end
        end
      end
      SERVE: begin
        if (instReady) begin
          pc_next = pc_reg + AW'(4);
          if (last_word) state_next = REQ;
        end
      end
      default: state_next = BOOT;
    endcase

    if (redirectValid) begin
      pc_next   = redir_pc;
      line_load = 1'b0;
      case (state_reg)
        BOOT: state_next = REQ;
        REQ: begin
          if (arReady) begin
            // The read went out with the old address; its data must be dropped.
            state_next = WAIT;
            drop_next  = 1'b1;
          end else begin
            state_next = redir_hit ? SERVE : REQ;
          end
        end
        WAIT: begin
          if (rValid) begin
            drop_next  = 1'b0;
            state_next = redir_hit ? SERVE : REQ;
          end else begin
            drop_next  = 1'b1;
            state_next = WAIT;
          end
        end
        SERVE: state_next = redir_hit ? SERVE : REQ;
        default: state_next = REQ;
      endcase
    end
  end

  // Outputs depend on state only; BOOT (also the reset state) drives zeros.
  always_comb begin
    arValid   = 1'b0;
    arAddr    = '0;
    rReady    = 1'b0;
    instValid = 1'b0;
    instPc    = '0;
    inst      = '0;
    case (state_reg)
      REQ: begin
        arValid = 1'b1;
        arAddr  = {pc_tag, {BW{1'b0}}};
      end
      WAIT: rReady = 1'b1;
      SERVE: begin
        instValid = 1'b1;
        instPc    = pc_reg;
        inst      = line_words[pc_reg[BW-1:2]];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_line_buffer.sv
// tb_fetch_line_buffer
//   Self-checking bench for fetch_line_buffer. A memory model answers line
//   reads; the stimulus side keeps an architectural fetch-PC model and pushes
//   the expected PC of every accepted instruction into a queue; a monitor
//   pops and compares whenever decode accepts an instruction.
module tb_fetch_line_buffer;

  logic         clk;
  logic         rst;
  logic         redirectValid;
  logic [15:0]  redirectPc;
  logic         instValid;
  logic         instReady;
  logic [31:0]  inst;
  logic [15:0]  instPc;
  logic         arValid;
  logic         arReady;
  logic [15:0]  arAddr;
  logic         rValid;
  logic         rReady;
  logic [127:0] rData;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];
  logic [15:0] model_pc;

  int mem_rand = 0;
  int mem_lat  = 1;

  fetch_line_buffer dut (
    .clk(clk), .rst(rst),
    .redirectValid(redirectValid), .redirectPc(redirectPc),
    .instValid(instValid), .instReady(instReady), .inst(inst), .instPc(instPc),
    .arValid(arValid), .arReady(arReady), .arAddr(arAddr),
    .rValid(rValid), .rReady(rReady), .rData(rData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory contents as a function of byte address: line 0 holds the
  // 0x11111111..0x44444444 pattern, every other word encodes its own address.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    logic [15:0] wa;
    wa = {a[15:2], 2'b00};
    if (wa < 16'd16) return 32'h11111111 * (32'(wa >> 2) + 32'd1);
    return {wa, wa ^ 16'hA5C3};
  endfunction

  function automatic logic [127:0] mem_line(input logic [15:0] a);
    logic [15:0] b;
    b = {a[15:4], 4'h0};
    return {mem_word(b + 16'd12), mem_word(b + 16'd8), mem_word(b + 16'd4), mem_word(b)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Account for the cycle just driven, then advance to the next cycle.
  task automatic step();
    if (!rst) begin
      if (instValid && instReady) begin
        exp_q.push_back(model_pc);
        model_pc = model_pc + 16'd4;
      end
      if (redirectValid) model_pc = {redirectPc[15:2], 2'b00};
    end
    @(posedge clk);
    #2;
  endtask

  task automatic redirect(input logic [15:0] target);
    redirectValid = 1'b1;
    redirectPc    = target;
    step();
    redirectValid = 1'b0;
  endtask

  task automatic wait_inst(input string name);
    int n = 0;
    while (!instValid && n < 50) begin step(); n++; end
    check(name, 32'(n < 50), 32'd1);
  endtask

  // Waits for a read request; also counts instructions offered meanwhile.
  task automatic wait_ar(input string name, output int seen);
    int n = 0;
    seen = 0;
    while (!arValid && n < 50) begin
      if (instValid) seen++;
      step();
      n++;
    end
    check(name, 32'(n < 50), 32'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_arValid"},  32'(arValid),   32'd0);
    check({tag, "_rReady"},   32'(rReady),    32'd0);
    check({tag, "_instValid"},32'(instValid), 32'd0);
    check({tag, "_arAddr"},   32'(arAddr),    32'd0);
    check({tag, "_inst"},     inst,           32'd0);
    check({tag, "_instPc"},   32'(instPc),    32'd0);
  endtask

  function automatic logic [15:0] pick_target();
    case ($urandom_range(0, 3))
      0:       return model_pc + 16'($urandom_range(0, 15));
      1:       return 16'($urandom_range(0, 65535));
      2:       return 16'hFFF0 + 16'($urandom_range(0, 15));
      default: return 16'($urandom_range(0, 63));
    endcase
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && instValid && instReady) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty: got instPc %h expected none", instPc);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("sb_instPc", 32'(instPc), 32'(e));
        check("sb_inst", inst, mem_word(e));
      end
    end
  end

  // Memory model: one outstanding read, configurable response latency.
  logic        pend;
  logic [15:0] paddr;
  int          delay;
  initial begin
    arReady = 1'b0;
    rValid  = 1'b0;
    rData   = '0;
    pend    = 1'b0;
    paddr   = '0;
    delay   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (rValid && rReady) pend = 1'b0;
        if (arValid && arReady) begin
          check("ar_single_outstanding", 32'(pend), 32'd0);
          pend  = 1'b1;
          paddr = arAddr;
          delay = (mem_rand != 0) ? int'($urandom_range(0, 3)) : mem_lat;
        end
      end
      @(posedge clk);
      #1;
      arReady = (mem_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pend && !rst) begin
        if (delay == 0) begin
          rValid = 1'b1;
          rData  = mem_line(paddr);
        end else begin
          delay--;
          rValid = 1'b0;
        end
      end else begin
        rValid = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] line0_words [4];
    logic [15:0] hold_pc;
    logic [31:0] hold_inst;
    int          n;
    int          seen;
    int          acc;

    line0_words[0] = 32'h11111111;
    line0_words[1] = 32'h22222222;
    line0_words[2] = 32'h33333333;
    line0_words[3] = 32'h44444444;

    rst = 1'b1;
    redirectValid = 1'b0;
    redirectPc = '0;
    instReady = 1'b0;
    model_pc = 16'h0000;
    step();
    step();
    check_zero_outputs("reset");

    // Release: one BOOT cycle, then the first request for RESET_PC.
    rst = 1'b0;
    check("boot_arValid", 32'(arValid), 32'd0);
    instReady = 1'b1;
    step();
    check("req_arValid", 32'(arValid), 32'd1);
    check("req_arAddr", 32'(arAddr), 32'h0000);

    n = 0;
    while (!instValid && n < 20) begin step(); n++; end
    check("miss_latency", 32'(n), 32'd3);

    for (int k = 0; k < 4; k++) begin
      check("stream_instValid", 32'(instValid), 32'd1);
      check("stream_instPc", 32'(instPc), 32'(k * 4));
      check("stream_inst", inst, line0_words[k]);
      step();
    end
    check("next_line_arValid", 32'(arValid), 32'd1);
    check("next_line_arAddr", 32'(arAddr), 32'h0010);

    // Decode stall: outputs hold, no memory traffic.
    instReady = 1'b0;
    wait_inst("stall_wait");
    check("stall_start_pc", 32'(instPc), 32'h0010);
    hold_pc = instPc;
    hold_inst = inst;
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_instValid", 32'(instValid), 32'd1);
      check("stall_instPc", 32'(instPc), 32'(hold_pc));
      check("stall_inst", inst, hold_inst);
      check("stall_arValid", 32'(arValid), 32'd0);
    end

    // Redirect that hits the buffered line.
    redirect(16'h0004);
    wait_inst("refill0_wait");
    check("refill0_pc", 32'(instPc), 32'h0004);
    redirect(16'h000B);
    check("hit_instValid", 32'(instValid), 32'd1);
    check("hit_instPc", 32'(instPc), 32'h0008);
    check("hit_inst", inst, 32'h33333333);
    check("hit_arValid", 32'(arValid), 32'd0);

    // Redirect while waiting for line 0x0010.
    redirect(16'h0010);
    n = 0;
    while (!rReady && n < 20) begin step(); n++; end
    check("wait_rReady", 32'(n < 20), 32'd1);
    redirect(16'h0120);
    wait_ar("drop_ar_wait", seen);
    check("drop_arAddr", 32'(arAddr), 32'h0120);
    check("drop_no_stale_inst", 32'(seen), 32'd0);
    instReady = 1'b1;
    wait_inst("drop_inst_wait");
    check("drop_instPc", 32'(instPc), 32'h0120);
    check("drop_inst", inst, mem_word(16'h0120));
    step();

    // Redirect in the same cycle as the returning data.
    instReady = 1'b0;
    redirect(16'h0200);
    n = 0;
    while (!(rValid && rReady) && n < 20) begin step(); n++; end
    check("same_cycle_rvalid", 32'(n < 20), 32'd1);
    redirect(16'h0014);
    wait_ar("same_ar_wait", seen);
    check("same_arAddr", 32'(arAddr), 32'h0010);
    check("same_no_stale_inst", 32'(seen), 32'd0);
    wait_inst("same_inst_wait");
    check("same_instPc", 32'(instPc), 32'h0014);

    // Address-space wrap.
    redirect(16'hFFFC);
    wait_inst("wrap_inst_wait");
    check("wrap_top_pc", 32'(instPc), 32'hFFFC);
    instReady = 1'b1;
    step();
    instReady = 1'b0;
    wait_ar("wrap_ar_wait", seen);
    check("wrap_arAddr", 32'(arAddr), 32'h0000);
    wait_inst("wrap_inst0_wait");
    check("wrap_instPc", 32'(instPc), 32'h0000);

    // Reset in the middle of a read.
    redirect(16'h0300);
    n = 0;
    while (!rReady && n < 20) begin step(); n++; end
    check("rst_wait_rReady", 32'(n < 20), 32'd1);
    rst = 1'b1;
    #1;
    check_zero_outputs("midrst");
    exp_q.delete();
    model_pc = 16'h0000;
    step();
    rst = 1'b0;
    wait_ar("rst_ar_wait", seen);
    check("rst_arAddr", 32'(arAddr), 32'h0000);

    // Randomized traffic with a randomly stalling memory.
    mem_rand = 1;
    acc = 0;
    for (int c = 0; c < 3000; c++) begin
      instReady = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) begin
        redirectValid = 1'b1;
        redirectPc = pick_target();
      end else begin
        redirectValid = 1'b0;
      end
      if (instValid && instReady) acc++;
      step();
    end
    redirectValid = 1'b0;
    instReady = 1'b0;
    step();
    check("random_progress", 32'(acc > 300), 32'd1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
